// File: rtl/user_stream_shell_if.sv
`default_nettype none
// ============================================================================
//  Module      : user_stream_shell_if
//  Description : Register-bus, stream and interrupt signal bundle for
//                user_stream_shell. slave = shell side, master = host side.
//  Revision    : 1.0  initial release
// ============================================================================
interface user_stream_shell_if #(
  parameter int NUM_STR = 4,
  parameter int DATA_W  = 64
);
  // register bus
  logic [31:0]               i_user_data;
  logic [19:0]               i_user_addr;
  logic                      i_user_wr_req;
  logic                      i_user_rd_req;
  logic [31:0]               o_user_data;
  logic                      o_user_rd_ack;
  // inbound streams (host -> shell)
  logic [NUM_STR-1:0]        i_pcie_str_data_valid;
  logic [NUM_STR-1:0]        o_pcie_str_ack;
  logic [NUM_STR*DATA_W-1:0] i_pcie_str_data;
  // outbound streams (shell -> host)
  logic [NUM_STR-1:0]        o_pcie_str_data_valid;
  logic [NUM_STR-1:0]        i_pcie_str_ack;
  logic [NUM_STR*DATA_W-1:0] o_pcie_str_data;
  // interrupt
  logic                      o_intr_req;
  logic                      i_intr_ack;

  modport slave (
    input  i_user_data, i_user_addr, i_user_wr_req, i_user_rd_req,
    output o_user_data, o_user_rd_ack,
    input  i_pcie_str_data_valid, i_pcie_str_data,
    output o_pcie_str_ack,
    output o_pcie_str_data_valid, o_pcie_str_data,
    input  i_pcie_str_ack,
    output o_intr_req,
    input  i_intr_ack
  );

  modport master (
    output i_user_data, i_user_addr, i_user_wr_req, i_user_rd_req,
    input  o_user_data, o_user_rd_ack,
    output i_pcie_str_data_valid, i_pcie_str_data,
    input  o_pcie_str_ack,
    input  o_pcie_str_data_valid, o_pcie_str_data,
    output i_pcie_str_ack,
    input  o_intr_req,
    output i_intr_ack
  );
endinterface
`default_nettype wire

// File: rtl/user_stream_shell.sv
`default_nettype none
// ============================================================================
//  Module      : user_stream_shell
//  Description : NUM_STR independent stream channels (FIFO + bypass/invert
//                at push + enable + output beat counter), an addressed
//                register bank and a beat-count interrupt with req/ack.
//  Revision    : 1.0  initial release
// ============================================================================
module user_stream_shell #(
  parameter int NUM_STR    = 4,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int REG_AW     = 4
) (
  input  wire logic          i_user_clk,
  input  wire logic          i_rst,
  user_stream_shell_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [REG_AW-1:0] IDX_CTRL   = REG_AW'(0);
  localparam logic [REG_AW-1:0] IDX_STATUS = REG_AW'(1);
  localparam logic [REG_AW-1:0] IDX_TARGET = REG_AW'(2);
  localparam logic [REG_AW-1:0] IDX_SCRTCH = REG_AW'(3);

  logic [REG_AW-1:0] reg_idx;
  logic              unused_addr_bits;

  logic [31:0] ctrl;
  logic [31:0] beat_target;
  logic [31:0] scratch;
  logic        pending;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic [31:0] rd_mux;
  logic [31:0] status;

  logic [NUM_STR-1:0]        empty;
  logic [NUM_STR-1:0]        full;
  logic [NUM_STR-1:0]        in_ack;
  logic [NUM_STR-1:0]        push;
  logic [NUM_STR-1:0]        pop;
  logic [NUM_STR-1:0]        cnt_clr;
  logic [NUM_STR*32-1:0]     counts_flat;
  logic [NUM_STR*DATA_W-1:0] heads_flat;

  logic [31:0] cnt0;
  logic        intr_set;

  // Only the word index selects a register; byte lanes and high bits are ignored.
  assign reg_idx          = bus.i_user_addr[REG_AW+1:2];
  assign unused_addr_bits = ^{bus.i_user_addr[19:REG_AW+2], bus.i_user_addr[1:0]};

  // --------------------------------------------------------------------------
  // Per-channel FIFO and beat counter
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_STR; c++) begin : g_chan
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [DATA_W-1:0] in_beat;
    logic [31:0]       cnt;

    assign in_beat  = bus.i_pcie_str_data[c*DATA_W +: DATA_W];
    // Extra wrap bit distinguishes full (wrap differs) from empty (identical).
    assign empty[c] = (wr_ptr == rd_ptr);
    assign full[c]  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    // Accept depends only on registered state, so a same-cycle pop never frees a full FIFO.
    assign in_ack[c]  = ctrl[c] & ~full[c];
    assign push[c]    = bus.i_pcie_str_data_valid[c] & in_ack[c];
    assign pop[c]     = ~empty[c] & bus.i_pcie_str_ack[c];
    assign cnt_clr[c] = bus.i_user_wr_req && (reg_idx == REG_AW'(4 + c));

    // Head is forced to zero while empty so stale storage never appears on the bus.
    assign heads_flat[c*DATA_W +: DATA_W] = empty[c] ? '0 : mem[rd_ptr[PTR_W-1:0]];
    assign counts_flat[c*32 +: 32]        = cnt;

    // Storage write; the data mode in force at push time is baked into the entry.
    always_ff @(posedge i_user_clk) begin
      if (push[c]) begin
        mem[wr_ptr[PTR_W-1:0]] <= ctrl[8+c] ? ~in_beat : in_beat;
      end
    end

    // Read/write pointers.
    always_ff @(posedge i_user_clk) begin
      if (i_rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[c]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[c])  rd_ptr <= rd_ptr + 1'b1;
      end
    end

    // Output beat counter: saturating, register write clears and wins over a pop.
    always_ff @(posedge i_user_clk) begin
      if (i_rst) begin
        cnt <= '0;
      end else if (cnt_clr[c]) begin
        cnt <= '0;
      end else if (pop[c] && (cnt != '1)) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register bank
  // --------------------------------------------------------------------------
  // Writable registers; RO and unmapped indices are ignored here.
  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      ctrl        <= '0;
      beat_target <= '0;
      scratch     <= '0;
    end else if (bus.i_user_wr_req) begin
      case (reg_idx)
        IDX_CTRL:   ctrl        <= bus.i_user_data;
        IDX_TARGET: beat_target <= bus.i_user_data;
        IDX_SCRTCH: scratch     <= bus.i_user_data;
        default:    ;
      endcase
    end
  end

  // Live status word assembled from FIFO flags and the interrupt flag.
  always_comb begin
    status = '0;
    for (int c = 0; c < NUM_STR; c++) begin
      status[c]   = empty[c];
      status[8+c] = full[c];
    end
    status[16] = pending;
  end

  // Read multiplexer over current register state; unmapped indices read 0.
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      IDX_CTRL:   rd_mux = ctrl;
      IDX_STATUS: rd_mux = status;
      IDX_TARGET: rd_mux = beat_target;
      IDX_SCRTCH: rd_mux = scratch;
      default: begin
        for (int c = 0; c < NUM_STR; c++) begin
          if (reg_idx == REG_AW'(4 + c)) rd_mux = counts_flat[c*32 +: 32];
        end
      end
    endcase
  end

  // Read response: ack one cycle after request, data held until the next read.
  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= bus.i_user_rd_req;
      if (bus.i_user_rd_req) rd_data <= rd_mux;
    end
  end

  // --------------------------------------------------------------------------
  // Beat-count interrupt
  // --------------------------------------------------------------------------
  assign cnt0     = counts_flat[31:0];
  assign intr_set = ctrl[16] && (beat_target != '0) && pop[0] && !cnt_clr[0] &&
                    (cnt0 != '1) && ((cnt0 + 32'd1) == beat_target);

  // Pending flag: a new hit outranks a simultaneous acknowledge.
  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      pending <= 1'b0;
    end else if (intr_set) begin
      pending <= 1'b1;
    end else if (bus.i_intr_ack) begin
      pending <= 1'b0;
    end
  end

  assign bus.o_user_data           = rd_data;
  assign bus.o_user_rd_ack         = rd_ack;
  assign bus.o_pcie_str_ack        = in_ack;
  assign bus.o_pcie_str_data_valid = ~empty;
  assign bus.o_pcie_str_data       = heads_flat;
  assign bus.o_intr_req            = pending;

endmodule
`default_nettype wire

// File: tb/tb_user_stream_shell.sv
`default_nettype none
// ============================================================================
//  Module      : tb_user_stream_shell
//  Description : Self-checking bench for user_stream_shell: directed scenarios
//                followed by random traffic, all outputs compared every cycle
//                against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_user_stream_shell;
  localparam int NUM_STR    = 4;
  localparam int DATA_W     = 64;
  localparam int FIFO_DEPTH = 16;
  localparam int REG_AW     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  user_stream_shell_if #(.NUM_STR(NUM_STR), .DATA_W(DATA_W)) bus ();

  user_stream_shell #(
    .NUM_STR(NUM_STR), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .REG_AW(REG_AW)
  ) dut (
    .i_user_clk(clk),
    .i_rst     (rst),
    .bus       (bus)
  );

  // reference model state
  logic [DATA_W-1:0] q [NUM_STR][$];
  logic [31:0] m_ctrl, m_target, m_scratch, m_rd_data;
  logic        m_rd_ack, m_pend;
  logic [31:0] m_cnt [NUM_STR];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_STR; c++) begin
      q[c].delete();
      m_cnt[c] = '0;
    end
    m_ctrl = '0; m_target = '0; m_scratch = '0;
    m_rd_data = '0; m_rd_ack = 1'b0; m_pend = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    logic [31:0] v;
    v = '0;
    case (idx)
      0: v = m_ctrl;
      1: begin
        for (int c = 0; c < NUM_STR; c++) begin
          v[c]   = (q[c].size() == 0);
          v[8+c] = (q[c].size() == FIFO_DEPTH);
        end
        v[16] = m_pend;
      end
      2: v = m_target;
      3: v = m_scratch;
      default: if (idx >= 4 && idx < 4 + NUM_STR) v = m_cnt[idx-4];
    endcase
    return v;
  endfunction

  // Compare every DUT output with what the model predicts for this cycle.
  task automatic compare_outputs();
    for (int c = 0; c < NUM_STR; c++) begin
      logic exp_ack;
      logic [63:0] exp_data;
      exp_ack  = m_ctrl[c] && (q[c].size() < FIFO_DEPTH);
      exp_data = (q[c].size() > 0) ? q[c][0] : 64'd0;
      check($sformatf("in_ack%0d", c), 64'(bus.o_pcie_str_ack[c]), 64'(exp_ack));
      check($sformatf("out_valid%0d", c), 64'(bus.o_pcie_str_data_valid[c]),
            64'(q[c].size() > 0));
      check($sformatf("out_data%0d", c), bus.o_pcie_str_data[c*DATA_W +: DATA_W], exp_data);
    end
    check("rd_ack", 64'(bus.o_user_rd_ack), 64'(m_rd_ack));
    check("rd_data", 64'(bus.o_user_data), 64'(m_rd_data));
    check("intr_req", 64'(bus.o_intr_req), 64'(m_pend));
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    int idx;
    logic inc0;
    logic [31:0] rd_next;
    if (rst) begin
      model_reset();
      return;
    end
    idx     = int'(bus.i_user_addr[REG_AW+1:2]);
    inc0    = 1'b0;
    rd_next = m_rd_data;
    if (bus.i_user_rd_req) rd_next = model_read(idx);
    for (int c = 0; c < NUM_STR; c++) begin
      logic do_pop, do_push;
      logic [63:0] beat;
      do_pop  = (q[c].size() > 0) && bus.i_pcie_str_ack[c];
      do_push = bus.i_pcie_str_data_valid[c] && m_ctrl[c] && (q[c].size() < FIFO_DEPTH);
      beat    = bus.i_pcie_str_data[c*DATA_W +: DATA_W];
      if (m_ctrl[8+c]) beat = ~beat;
      if (do_pop)  void'(q[c].pop_front());
      if (do_push) q[c].push_back(beat);
      if (bus.i_user_wr_req && idx == 4 + c) m_cnt[c] = '0;
      else if (do_pop && m_cnt[c] != 32'hFFFF_FFFF) begin
        m_cnt[c] = m_cnt[c] + 1;
        if (c == 0) inc0 = 1'b1;
      end
    end
    if (inc0 && m_ctrl[16] && m_target != 0 && m_cnt[0] == m_target) m_pend = 1'b1;
    else if (bus.i_intr_ack) m_pend = 1'b0;
    if (bus.i_user_wr_req) begin
      case (idx)
        0: m_ctrl    = bus.i_user_data;
        2: m_target  = bus.i_user_data;
        3: m_scratch = bus.i_user_data;
        default: ;
      endcase
    end
    m_rd_ack  = bus.i_user_rd_req;
    m_rd_data = rd_next;
  endtask

  task automatic cycle();
    compare_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input int idx, input logic [31:0] d);
    bus.i_user_addr   = 20'(idx * 4);
    bus.i_user_data   = d;
    bus.i_user_wr_req = 1'b1;
    cycle();
    bus.i_user_wr_req = 1'b0;
  endtask

  task automatic reg_rd(input int idx, output logic [31:0] d);
    bus.i_user_addr   = 20'(idx * 4);
    bus.i_user_rd_req = 1'b1;
    cycle();
    bus.i_user_rd_req = 1'b0;
    check("rd_ack_pulse", 64'(bus.o_user_rd_ack), 64'd1);
    d = bus.o_user_data;
  endtask

  task automatic set_beat(input int c, input logic [63:0] d);
    bus.i_pcie_str_data[c*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1;
    bus.i_user_data = '0; bus.i_user_addr = '0;
    bus.i_user_wr_req = 1'b0; bus.i_user_rd_req = 1'b0;
    bus.i_pcie_str_data_valid = '0; bus.i_pcie_str_data = '0;
    bus.i_pcie_str_ack = '0; bus.i_intr_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // reset state
    check("rst_in_ack", 64'(bus.o_pcie_str_ack), 64'd0);
    check("rst_out_valid", 64'(bus.o_pcie_str_data_valid), 64'd0);
    check("rst_rd_ack", 64'(bus.o_user_rd_ack), 64'd0);
    check("rst_rd_data", 64'(bus.o_user_data), 64'd0);
    check("rst_intr", 64'(bus.o_intr_req), 64'd0);
    reg_rd(0, v);
    check("rd_ctrl_after_rst", 64'(v), 64'd0);
    cycle();
    check("rd_ack_one_cycle", 64'(bus.o_user_rd_ack), 64'd0);

    // bypass on channel 2
    reg_wr(0, 32'h0000_000F);
    bus.i_pcie_str_ack = 4'b0100;
    set_beat(2, 64'h0123_4567_89AB_CDEF);
    bus.i_pcie_str_data_valid = 4'b0100;
    cycle();
    bus.i_pcie_str_data_valid = '0;
    check("ch2_valid", 64'(bus.o_pcie_str_data_valid[2]), 64'd1);
    check("ch2_bypass", bus.o_pcie_str_data[2*DATA_W +: DATA_W], 64'h0123_4567_89AB_CDEF);
    cycle();
    reg_rd(6, v);
    check("count2_one", 64'(v), 64'd1);

    // invert on channel 2
    reg_wr(0, 32'h0000_040F);
    set_beat(2, 64'd0);
    bus.i_pcie_str_data_valid = 4'b0100;
    cycle();
    bus.i_pcie_str_data_valid = '0;
    check("ch2_invert", bus.o_pcie_str_data[2*DATA_W +: DATA_W], 64'hFFFF_FFFF_FFFF_FFFF);
    cycle();

    // fill channel 0 to full, then drain in order
    bus.i_pcie_str_ack = '0;
    bus.i_pcie_str_data_valid = 4'b0001;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      set_beat(0, 64'hA5A5_0000_0000_0000 + 64'(i));
      check("fill_in_ack0", 64'(bus.o_pcie_str_ack[0]), 64'(i < FIFO_DEPTH));
      cycle();
    end
    bus.i_pcie_str_data_valid = '0;
    reg_rd(1, v);
    check("status_full0", 64'(v[8]), 64'd1);
    bus.i_pcie_str_ack = 4'b0001;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      check("drain_order0", bus.o_pcie_str_data[0 +: DATA_W], 64'hA5A5_0000_0000_0000 + 64'(i));
      cycle();
    end
    reg_rd(1, v);
    check("status_empty0", 64'(v[0]), 64'd1);

    // beat-count interrupt on channel 0
    reg_wr(4, 32'd0);
    reg_wr(2, 32'd3);
    reg_wr(0, 32'h0001_0001);
    bus.i_pcie_str_data_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      set_beat(0, 64'(k + 100));
      check("intr_before_3rd", 64'(bus.o_intr_req), 64'd0);
      cycle();
    end
    check("intr_rise", 64'(bus.o_intr_req), 64'd1);
    set_beat(0, 64'd104);
    bus.i_intr_ack = 1'b1;
    cycle();
    bus.i_intr_ack = 1'b0;
    bus.i_pcie_str_data_valid = '0;
    check("intr_acked", 64'(bus.o_intr_req), 64'd0);
    repeat (3) begin
      cycle();
      check("intr_stays_low", 64'(bus.o_intr_req), 64'd0);
    end

    // count clear colliding with a pop on channel 1
    reg_wr(0, 32'h0000_0002);
    bus.i_pcie_str_ack = '0;
    bus.i_pcie_str_data_valid = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      set_beat(1, 64'(i + 1));
      cycle();
    end
    bus.i_pcie_str_data_valid = '0;
    bus.i_pcie_str_ack = 4'b0010;
    repeat (7) cycle();
    bus.i_pcie_str_ack = '0;
    reg_rd(5, v);
    check("count1_seven", 64'(v), 64'd7);
    bus.i_pcie_str_ack = 4'b0010;
    reg_wr(5, 32'h1234_5678);
    bus.i_pcie_str_ack = '0;
    reg_rd(5, v);
    check("count1_clear_wins", 64'(v), 64'd0);

    // scratch, and read/write collision returns the old value
    reg_wr(3, 32'hDEAD_BEEF);
    reg_rd(3, v);
    check("scratch_rw", 64'(v), 64'hDEAD_BEEF);
    bus.i_user_addr = 20'(3 * 4);
    bus.i_user_data = 32'h1234_5678;
    bus.i_user_wr_req = 1'b1;
    bus.i_user_rd_req = 1'b1;
    cycle();
    bus.i_user_wr_req = 1'b0;
    bus.i_user_rd_req = 1'b0;
    check("rdwr_old_value", 64'(bus.o_user_data), 64'hDEAD_BEEF);
    reg_rd(3, v);
    check("scratch_new", 64'(v), 64'h1234_5678);

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int widx;
      bus.i_pcie_str_data_valid = 4'($urandom);
      bus.i_pcie_str_ack        = 4'($urandom);
      for (int c = 0; c < NUM_STR; c++) set_beat(c, {$urandom, $urandom});
      bus.i_intr_ack    = ($urandom_range(0, 3) == 0);
      bus.i_user_rd_req = ($urandom_range(0, 3) == 0);
      bus.i_user_wr_req = ($urandom_range(0, 5) == 0);
      widx              = $urandom_range(0, 15);
      if (bus.i_user_wr_req) begin
        widx = $urandom_range(0, 9);
        if (widx > 7) widx = 4;
      end
      bus.i_user_addr = {12'($urandom), 4'(widx), 2'($urandom)};
      case (widx)
        0:       bus.i_user_data = $urandom | 32'h0001_0001;
        2:       bus.i_user_data = $urandom_range(0, 6);
        default: bus.i_user_data = $urandom;
      endcase
      rst = ($urandom_range(0, 799) == 0);
      cycle();
    end
    rst = 1'b0;
    bus.i_user_wr_req = 1'b0;
    bus.i_user_rd_req = 1'b0;
    bus.i_pcie_str_data_valid = '0;
    bus.i_intr_ack = 1'b0;

    // mid-stream reset discards queued beats
    reg_wr(0, 32'h0000_000F);
    bus.i_pcie_str_ack = '0;
    bus.i_pcie_str_data_valid = 4'b1111;
    repeat (3) cycle();
    bus.i_pcie_str_data_valid = '0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("post_rst_valid", 64'(bus.o_pcie_str_data_valid), 64'd0);
    check("post_rst_in_ack", 64'(bus.o_pcie_str_ack), 64'd0);
    cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/user_stream_shell.md
Name: user_stream_shell

Overview:
- Parametrised successor to the fixed four-channel user logic wrapper.
- Provides NUM_STR independent 64-bit PCIe stream channels. Each channel has a FIFO, a per-channel bypass/invert data mode, enable control and an output beat counter.
- Provides an addressed register bank and a beat-count interrupt with request/ack handshake.
- Sits between the PCIe stream/register interfaces and user accelerators, or acts as a standalone loopback test target.

Parameters:
- NUM_STR, 4, number of stream channels (1..8).
- DATA_W, 64, stream data width per channel.
- FIFO_DEPTH, 16, entries per channel FIFO (power of 2, ≥2).
- REG_AW, 4, register index width; index = i_user_addr[REG_AW+1:2].

Ports:
- i_user_clk  in  1  single clock, all logic rising-edge.
- i_rst  in  1  synchronous reset, active-high.
- i_user_data  in  32  register write data.
- i_user_addr  in  20  register byte address.
- i_user_wr_req  in  1  register write strobe, one cycle.
- i_user_rd_req  in  1  register read strobe, one cycle.
- o_user_data  out  32  register read data.
- o_user_rd_ack  out  1  read acknowledge.
- i_pcie_str_data_valid  in  NUM_STR  per-channel input valid.
- o_pcie_str_ack  out  NUM_STR  per-channel input accept.
- i_pcie_str_data  in  NUM_STR*DATA_W  input data; channel c = bits [c*DATA_W +: DATA_W].
- o_pcie_str_data_valid  out  NUM_STR  per-channel output valid.
- i_pcie_str_ack  in  NUM_STR  per-channel output accept.
- o_pcie_str_data  out  NUM_STR*DATA_W  output data, same packing.
- o_intr_req  out  1  interrupt request.
- i_intr_ack  in  1  interrupt acknowledge.

Behaviour:
- Reset (i_rst high at clock edge): all registers, counters, pending flag = 0; FIFOs empty. o_user_rd_ack=0, o_user_data=0, o_pcie_str_ack=0, o_pcie_str_data_valid=0, o_intr_req=0. Reset mid-transfer discards FIFO contents.
- Register map (word index):
  - 0 CTRL RW: [NUM_STR-1:0] channel enable; [8+c] invert mode for channel c; [16] interrupt enable.
  - 1 STATUS RO: [c] FIFO c empty; [8+c] FIFO c full; [16] interrupt pending.
  - 2 BEAT_TARGET RW.
  - 3 SCRATCH RW.
  - 4+c COUNT_c RO: output beats on channel c. Any write to 4+c clears COUNT_c.
  - Writes to RO/unmapped indices have no effect except the clear above. Reads of unmapped indices return 0.
- Register read: o_user_rd_ack = i_user_rd_req delayed one cycle. o_user_data is registered and valid in the ack cycle, holding until the next read.
- Register write takes effect the cycle after i_user_wr_req. Simultaneous rd/wr to the same index returns the old value.
- Input handshake: o_pcie_str_ack[c] = CTRL[c] & !full_c, combinational from registered state. A beat is pushed when valid & ack. No push when full, even if a pop occurs in the same cycle.
- Output handshake: o_pcie_str_data_valid[c] = !empty_c. o_pcie_str_data shows the FIFO head (first-word fall-through), held stable until i_pcie_str_ack[c]. Pop when valid & ack.
- Data mode is applied at push: invert stores ~data, bypass stores data unchanged. Changing the mode does not alter beats already queued.
- Channel disable mid-stream: ack drops next cycle; queued beats still drain.
- Full at FIFO_DEPTH entries. Pointers wrap modulo FIFO_DEPTH, with an extra wrap bit for the full/empty distinction.
- Push and pop in the same cycle (non-empty, non-full): occupancy unchanged.
- COUNT_c increments on each pop and saturates at 0xFFFFFFFF. A clear in the same cycle as a pop wins: result 0.
- Interrupt:
  - Pending sets when CTRL[16]=1, BEAT_TARGET≠0, and COUNT_0 increments to exactly BEAT_TARGET.
  - o_intr_req = pending. i_intr_ack clears pending the next cycle.
  - Set and ack in the same cycle: set wins.
  - Clearing CTRL[16] does not clear pending.
- Latency: input accept to output valid = 1 cycle (empty FIFO).

Test Plan:
- Reset with i_rst=1 for 2 cycles → all outputs 0. Read index 0 → o_user_rd_ack pulses 1 cycle after req, data 0x00000000.
- CTRL=0x0000000F; push 0x0123456789ABCDEF on ch2 with out ack=1 → data appears on ch2 one cycle later unchanged. COUNT_2 reads 1.
- CTRL=0x0000040F (ch2 invert); push 0x0 → output 0xFFFFFFFFFFFFFFFF.
- Ch0 enabled, i_pcie_str_ack[0]=0; push 16 beats → 16 accepted, ack low on beat 17, STATUS[8]=1. Assert out ack → 16 beats drain in order, then STATUS[0]=1.
- BEAT_TARGET=3, CTRL=0x00010001; stream 5 beats on ch0 → o_intr_req rises the cycle after 3rd pop. Pulse i_intr_ack → low next cycle, not re-raised by beats 4–5.
- COUNT_1 at 7, write to index 5 during a pop → COUNT_1 reads 0. SCRATCH write 0xDEADBEEF reads back the same value.
